cam_masked: RTL and testbench

CAM_MASKED -- requirements
Module: cam_masked

---
 rtl/cam_pkg.sv | 9 +
 rtl/cam_prio_enc.sv | 25 ++
 rtl/cam_masked.sv | 94 +++++++++
 tb/tb_cam_masked.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared constants and types for the masked CAM.
// Default geometry: 32-bit entries, 32 entries.
package cam_pkg;
  localparam int CAM_DATA_WIDTH = 32;
  localparam int CAM_DEPTH_LOG2 = 5;

  typedef logic [CAM_DATA_WIDTH-1:0] cam_entry_t;
  typedef logic [CAM_DEPTH_LOG2-1:0] cam_index_t;
endpackage

// File: rtl/cam_prio_enc.sv
// Match-vector priority encoder: any hit, lowest hit index, more than one hit.
// Purely combinational; no flow control.
// No backpressure: result follows the match vector directly.
module cam_prio_enc #(
  parameter int IDX_W = 5
) (
  input  logic [(1<<IDX_W)-1:0] match,
  output logic                  any,
  output logic [IDX_W-1:0]      index,
  output logic                  multi
);
  localparam int N = 1 << IDX_W;

  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (match[i]) index = i[IDX_W-1:0];
    end
  end

  assign any   = |match;
  // Clearing the lowest set bit leaves something only when two or more were set.
  assign multi = |(match & (match - N'(1)));
endmodule

// File: rtl/cam_masked.sv
// Masked-search CAM with indexed read/write/invalidate and occupancy tracking.
// Read and search results are registered: 1-cycle latency.
// No backpressure: every request is accepted each cycle.
module cam_masked
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int DEPTH_LOG2 = CAM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  read_i,
  input  logic [DEPTH_LOG2-1:0] read_index_i,
  input  logic                  write_i,
  input  logic [DEPTH_LOG2-1:0] write_index_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  inval_i,
  input  logic [DEPTH_LOG2-1:0] inval_index_i,
  input  logic                  search_i,
  input  logic [DATA_WIDTH-1:0] search_data_i,
  input  logic [DATA_WIDTH-1:0] search_mask_i,
  output logic                  read_valid_o,
  output logic [DATA_WIDTH-1:0] read_value_o,
  output logic                  search_valid_o,
  output logic [DEPTH_LOG2-1:0] search_index_o,
  output logic                  search_multi_o,
  output logic [DEPTH_LOG2:0]   occupancy_o,
  output logic                  full_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      match;
  logic                  same_idx, wr_en, occ_inc, occ_dec;
  logic                  hit_any, hit_multi;
  logic [DEPTH_LOG2-1:0] hit_index;

  // Invalidate beats a write to the same entry in the same cycle.
  assign same_idx = write_i && inval_i && (write_index_i == inval_index_i);
  assign wr_en    = write_i && !same_idx;
  assign occ_inc  = wr_en && !valid_q[write_index_i];
  assign occ_dec  = inval_i && valid_q[inval_index_i];

  always_ff @(posedge clk) begin
    if (wr_en) data_q[write_index_i] <= write_data_i;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      valid_q     <= '0;
      occupancy_o <= '0;
    end else begin
      if (wr_en)   valid_q[write_index_i] <= 1'b1;
      if (inval_i) valid_q[inval_index_i] <= 1'b0;
      occupancy_o <= occupancy_o + CW'(occ_inc) - CW'(occ_dec);
    end
  end

  assign full_o = (occupancy_o == FULL_CNT);

  // Lookups use pre-update state, so same-cycle writes are not visible yet.
  always_comb begin
    match = '0;
    for (int e = 0; e < DEPTH; e++) begin
      match[e] = valid_q[e] && (((data_q[e] ^ search_data_i) & search_mask_i) == '0);
    end
  end

  cam_prio_enc #(.IDX_W(DEPTH_LOG2)) u_prio_enc (
    .match (match),
    .any   (hit_any),
    .index (hit_index),
    .multi (hit_multi)
  );

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      read_valid_o   <= 1'b0;
      read_value_o   <= '0;
      search_valid_o <= 1'b0;
      search_index_o <= '0;
      search_multi_o <= 1'b0;
    end else begin
      read_valid_o <= read_i && valid_q[read_index_i];
      if (read_i) read_value_o <= valid_q[read_index_i] ? data_q[read_index_i] : '0;
      search_valid_o <= search_i && hit_any;
      search_index_o <= (search_i && hit_any) ? hit_index : '0;
      search_multi_o <= search_i && hit_multi;
    end
  end
endmodule

// File: tb/tb_cam_masked.sv
// Randomized and directed bench for cam_masked against an array-based reference model.
module tb_cam_masked;
  localparam int DW    = 32;
  localparam int DL    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          read_i, write_i, inval_i, search_i;
  logic [DL-1:0] read_index_i, write_index_i, inval_index_i;
  logic [DW-1:0] write_data_i, search_data_i, search_mask_i;
  logic          read_valid_o, search_valid_o, search_multi_o, full_o;
  logic [DW-1:0] read_value_o;
  logic [DL-1:0] search_index_o;
  logic [DL:0]   occupancy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_data [DEPTH];
  bit            m_valid[DEPTH];
  logic [DW-1:0] m_rd_val;
  bit            e_rv, e_sv, e_sm;
  int            e_si;

  cam_masked #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset_i(reset_i),
    .read_i(read_i), .read_index_i(read_index_i),
    .write_i(write_i), .write_index_i(write_index_i), .write_data_i(write_data_i),
    .inval_i(inval_i), .inval_index_i(inval_index_i),
    .search_i(search_i), .search_data_i(search_data_i), .search_mask_i(search_mask_i),
    .read_valid_o(read_valid_o), .read_value_o(read_value_o),
    .search_valid_o(search_valid_o), .search_index_o(search_index_o),
    .search_multi_o(search_multi_o), .occupancy_o(occupancy_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    read_i = 0; write_i = 0; inval_i = 0; search_i = 0;
    read_index_i = '0; write_index_i = '0; inval_index_i = '0;
    write_data_i = '0; search_data_i = '0; search_mask_i = '0;
  endtask

  task automatic model_clear();
    for (int e = 0; e < DEPTH; e++) begin
      m_valid[e] = 0;
      m_data[e]  = '0;
    end
    m_rd_val = '0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int e = 0; e < DEPTH; e++) c += m_valid[e] ? 1 : 0;
    return c;
  endfunction

  // Computes expectations from the current contents, applies the update, clocks once, compares.
  task automatic cycle();
    int hits;
    int occ;
    hits = 0;
    e_si = 0;
    e_rv = read_i && m_valid[read_index_i];
    if (read_i) m_rd_val = e_rv ? m_data[read_index_i] : '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (m_valid[e] && (((m_data[e] ^ search_data_i) & search_mask_i) == '0)) begin
        if (hits == 0) e_si = e;
        hits++;
      end
    end
    e_sv = search_i && (hits > 0);
    e_sm = search_i && (hits > 1);
    if (!e_sv) e_si = 0;
    if (write_i) begin
      m_data[write_index_i]  = write_data_i;
      m_valid[write_index_i] = 1;
    end
    if (inval_i) m_valid[inval_index_i] = 0;
    occ = model_count();
    @(posedge clk);
    #1;
    check("read_valid", read_valid_o, e_rv);
    check("read_value", read_value_o, m_rd_val);
    check("search_valid", search_valid_o, e_sv);
    check("search_index", search_index_o, e_si);
    check("search_multi", search_multi_o, e_sm);
    check("occupancy", occupancy_o, occ);
    check("full", full_o, occ == DEPTH);
    idle();
  endtask

  task automatic wr(input int idx, input logic [DW-1:0] d);
    write_i = 1; write_index_i = DL'(idx); write_data_i = d;
    cycle();
  endtask

  task automatic rd(input int idx);
    read_i = 1; read_index_i = DL'(idx);
    cycle();
  endtask

  task automatic inv(input int idx);
    inval_i = 1; inval_index_i = DL'(idx);
    cycle();
  endtask

  task automatic srch(input logic [DW-1:0] d, input logic [DW-1:0] m);
    search_i = 1; search_data_i = d; search_mask_i = m;
    cycle();
  endtask

  initial begin
    idle();
    model_clear();
    reset_i = 0;
    #12;
    check("rst_read_valid", read_valid_o, 0);
    check("rst_read_value", read_value_o, 0);
    check("rst_search_valid", search_valid_o, 0);
    check("rst_occupancy", occupancy_o, 0);
    check("rst_full", full_o, 0);
    @(negedge clk);
    reset_i = 1;

    // Basic writes and reads
    wr(1, 32'h1); wr(3, 32'h3); wr(5, 32'h5); wr(7, 32'h7);
    check("occ_four", occupancy_o, 4);
    rd(3);
    check("read3_value", read_value_o, 32'h3);
    rd(4);
    check("read4_valid", read_valid_o, 0);

    // Duplicate key: lowest index wins, multi set
    wr(9, 32'h5);
    srch(32'h5, 32'hFFFF_FFFF);
    check("dup_index", search_index_o, 5);
    check("dup_multi", search_multi_o, 1);
    inv(5);
    srch(32'h5, 32'hFFFF_FFFF);
    check("after_inval_index", search_index_o, 9);
    check("after_inval_multi", search_multi_o, 0);

    // Read-before-write in the same cycle
    wr(5, 32'h5);
    read_i = 1; read_index_i = 5; write_i = 1; write_index_i = 5; write_data_i = 32'h9;
    cycle();
    check("rbw_value", read_value_o, 32'h5);
    srch(32'h9, 32'hFFFF_FFFF);
    check("rbw_search_index", search_index_o, 5);

    // Partial mask, then empty CAM with all-zero mask
    for (int i = 0; i < DEPTH; i++) inv(i);
    wr(2, 32'h12); wr(6, 32'h1F);
    srch(32'h10, 32'hF0);
    check("mask_index", search_index_o, 2);
    check("mask_multi", search_multi_o, 1);
    inv(2); inv(6);
    srch(32'h1234, 32'h0);
    check("empty_mask0_valid", search_valid_o, 0);

    // Fill, then same-index write+inval
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom);
    check("full_set", full_o, 1);
    write_i = 1; write_index_i = 0; write_data_i = 32'hABCD;
    inval_i = 1; inval_index_i = 0;
    cycle();
    check("occ_after_wr_inval", occupancy_o, DEPTH - 1);
    rd(0);
    check("idx0_invalid", read_valid_o, 0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      read_i = 1'($urandom_range(0, 1));
      read_index_i = DL'($urandom_range(0, DEPTH - 1));
      write_i = ($urandom_range(0, 2) != 0);
      write_index_i = DL'($urandom_range(0, DEPTH - 1));
      write_data_i = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 15));
      inval_i = ($urandom_range(0, 3) == 0);
      inval_index_i = ($urandom_range(0, 3) == 0) ? write_index_i : DL'($urandom_range(0, DEPTH - 1));
      search_i = 1'($urandom_range(0, 1));
      search_data_i = DW'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: search_mask_i = 32'hFFFF_FFFF;
        1: search_mask_i = 32'hF;
        2: search_mask_i = 32'h0;
        default: search_mask_i = DW'($urandom);
      endcase
      cycle();
    end

    // Asynchronous reset during a search
    wr(4, 32'h44);
    search_i = 1; search_data_i = 32'h44; search_mask_i = 32'hFFFF_FFFF;
    read_i = 1; read_index_i = 4;
    @(posedge clk);
    #3;
    reset_i = 0;
    #1;
    check("mid_rst_search_valid", search_valid_o, 0);
    check("mid_rst_search_index", search_index_o, 0);
    check("mid_rst_read_valid", read_valid_o, 0);
    check("mid_rst_read_value", read_value_o, 0);
    check("mid_rst_occupancy", occupancy_o, 0);
    check("mid_rst_full", full_o, 0);
    idle();
    model_clear();
    @(posedge clk);
    #1;
    check("in_rst_search_valid", search_valid_o, 0);
    @(negedge clk);
    reset_i = 1;
    cycle();
    check("post_rst_no_stale", search_valid_o, 0);
    rd(4);
    check("post_rst_read4", read_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
